// File: rtl/bubbledrive8_pkg.sv
// Shared encodings and default 48 MHz timing for the bubbledrive8 power monitor.
package bubbledrive8_pkg;

    // Validated {PWRSTAT, MRST} power modes
    localparam logic [1:0] MODE_EMULATOR   = 2'b00;
    localparam logic [1:0] MODE_ERR_BADRAIL = 2'b01;
    localparam logic [1:0] MODE_ERR_AMBIG  = 2'b10;
    localparam logic [1:0] MODE_STANDBY    = 2'b11;

    // Settle FSM states
    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_SETTLING = 2'd1;
    localparam logic [1:0] ST_VALID    = 2'd2;

    // Default timing at 48 MHz: 1 ms debounce, 100 ms settle
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 48000;
    localparam int unsigned DEF_SETTLE_CYCLES   = 4800000;
    localparam int unsigned DEF_CNT_W           = 23;

    // Combine the two debounced pins into a mode code
    function automatic logic [1:0] pack_mode(input logic pwrstat, input logic mrst);
        return {pwrstat, mrst};
    endfunction

endpackage

// File: rtl/bubbledrive8_debounce.sv
// Synchronizer plus debouncer for one asynchronous board pin.
// During INIT the counter is frozen and glitches are not reported;
// i_load copies the synced level straight into the stable register.
module bubbledrive8_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 48000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    input  logic i_init,
    input  logic i_load,
    output logic o_stable,
    output logic o_change_c,
    output logic o_glitch_c
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;
    logic [DB_W-1:0]        r_cnt;

    logic                   w_synced;
    logic                   w_mismatch;
    logic [SYNC_STAGES-1:0] w_sync_nxt;
    logic                   w_stable_nxt;
    logic [DB_W-1:0]        w_cnt_nxt;

    assign w_synced   = r_sync[SYNC_STAGES-1];
    assign w_mismatch = (w_synced != r_stable);
    assign w_sync_nxt = {r_sync[SYNC_STAGES-2:0], i_pin};
    assign o_stable   = r_stable;

    // Mismatch counting, acceptance and glitch detection
    always_comb begin
        w_stable_nxt = r_stable;
        w_cnt_nxt    = '0;
        o_change_c   = 1'b0;
        o_glitch_c   = 1'b0;
        if (i_init) begin
            if (i_load) begin
                w_stable_nxt = w_synced;
            end
        end else if (w_mismatch) begin
            if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                w_stable_nxt = w_synced;
                o_change_c   = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + DB_W'(1);
            end
        end else if (r_cnt != '0) begin
            o_glitch_c = 1'b1;
        end
    end

    // Sync chain, stable level and mismatch counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync   <= w_sync_nxt;
            r_stable <= w_stable_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/bubbledrive8_pwrmon.sv
// Power-status conditioner: debounces PWRSTAT/MRST, waits for a settle
// interval, then publishes a validated MODE and counts rejected glitches.
module bubbledrive8_pwrmon
    import bubbledrive8_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic       MCLK,
    input  logic       RST,
    input  logic       PWRSTAT,
    input  logic       MRST,
    output logic       PWRSTAT_STABLE,
    output logic       MRST_STABLE,
    output logic [1:0] MODE,
    output logic       MODE_VALID,
    output logic       MODE_CHG,
    output logic [7:0] GLITCH_CNT
);

    localparam int unsigned INIT_W = $clog2(SYNC_STAGES + 1);

    logic [1:0]       r_state;
    logic [INIT_W-1:0] r_init_cnt;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [1:0]       r_mode;
    logic             r_mode_valid;
    logic             r_mode_chg;
    logic [7:0]       r_glitch_cnt;

    logic [1:0]       w_state_nxt;
    logic [INIT_W-1:0] w_init_cnt_nxt;
    logic [CNT_W-1:0] w_settle_cnt_nxt;
    logic [1:0]       w_mode_nxt;
    logic             w_mode_valid_nxt;
    logic             w_mode_chg_nxt;
    logic [7:0]       w_glitch_cnt_nxt;

    logic             w_in_init;
    logic             w_load;
    logic             w_stable_p;
    logic             w_stable_m;
    logic             w_chg_p;
    logic             w_chg_m;
    logic             w_glitch_p;
    logic             w_glitch_m;
    logic             w_any_chg;
    logic [8:0]       w_glitch_sum;

    assign w_in_init    = (r_state == ST_INIT);
    assign w_load       = w_in_init && (r_init_cnt == INIT_W'(SYNC_STAGES));
    assign w_any_chg    = w_chg_p | w_chg_m;
    assign w_glitch_sum = 9'(r_glitch_cnt) + 9'(w_glitch_p) + 9'(w_glitch_m);

    bubbledrive8_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_pwrstat (
        .i_clk     (MCLK),
        .i_rst     (RST),
        .i_pin     (PWRSTAT),
        .i_init    (w_in_init),
        .i_load    (w_load),
        .o_stable  (w_stable_p),
        .o_change_c(w_chg_p),
        .o_glitch_c(w_glitch_p)
    );

    bubbledrive8_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_mrst (
        .i_clk     (MCLK),
        .i_rst     (RST),
        .i_pin     (MRST),
        .i_init    (w_in_init),
        .i_load    (w_load),
        .o_stable  (w_stable_m),
        .o_change_c(w_chg_m),
        .o_glitch_c(w_glitch_m)
    );

    // Next-state and output logic; a stable change always beats settle completion
    always_comb begin
        w_state_nxt      = r_state;
        w_init_cnt_nxt   = r_init_cnt;
        w_settle_cnt_nxt = r_settle_cnt;
        w_mode_nxt       = r_mode;
        w_mode_valid_nxt = r_mode_valid;
        w_mode_chg_nxt   = 1'b0;
        w_glitch_cnt_nxt = w_glitch_sum[8] ? 8'hFF : w_glitch_sum[7:0];
        case (r_state)
            ST_INIT: begin
                if (w_load) begin
                    w_state_nxt      = ST_SETTLING;
                    w_settle_cnt_nxt = '0;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + INIT_W'(1);
                end
            end
            ST_SETTLING: begin
                w_mode_valid_nxt = 1'b0;
                if (w_any_chg) begin
                    w_settle_cnt_nxt = '0;
                end else if (r_settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_mode_nxt       = pack_mode(w_stable_p, w_stable_m);
                    w_mode_valid_nxt = 1'b1;
                    w_mode_chg_nxt   = 1'b1;
                    w_settle_cnt_nxt = '0;
                    w_state_nxt      = ST_VALID;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + CNT_W'(1);
                end
            end
            ST_VALID: begin
                if (w_any_chg) begin
                    w_mode_valid_nxt = 1'b0;
                    w_settle_cnt_nxt = '0;
                    w_state_nxt      = ST_SETTLING;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_settle_cnt <= '0;
            r_mode       <= MODE_EMULATOR;
            r_mode_valid <= 1'b0;
            r_mode_chg   <= 1'b0;
            r_glitch_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_init_cnt   <= w_init_cnt_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_mode       <= w_mode_nxt;
            r_mode_valid <= w_mode_valid_nxt;
            r_mode_chg   <= w_mode_chg_nxt;
            r_glitch_cnt <= w_glitch_cnt_nxt;
        end
    end

    assign PWRSTAT_STABLE = w_stable_p;
    assign MRST_STABLE    = w_stable_m;
    assign MODE           = r_mode;
    assign MODE_VALID     = r_mode_valid;
    assign MODE_CHG       = r_mode_chg;
    assign GLITCH_CNT     = r_glitch_cnt;

endmodule

// File: tb/tb_bubbledrive8_pwrmon.sv
// Directed + randomized bench for bubbledrive8_pwrmon with a pin-history model.
module tb_bubbledrive8_pwrmon;

    localparam int SYNC   = 2;
    localparam int DEB    = 4;
    localparam int SETTLE = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwr;
    logic       mrst;
    logic       pwr_stable;
    logic       mrst_stable;
    logic [1:0] mode;
    logic       mode_valid;
    logic       mode_chg;
    logic [7:0] glitch_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: pin delay lines, accepted levels, run lengths, last change edge
    logic       q_p[$];
    logic       q_m[$];
    logic       m_stab_p, m_stab_m;
    int         m_run_p, m_run_m;
    int         m_n, m_last, m_g;
    logic [1:0] m_mode;
    logic       m_valid, m_chgp;

    always #5 clk = ~clk;

    bubbledrive8_pwrmon #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (SETTLE),
        .CNT_W          (23)
    ) dut (
        .MCLK          (clk),
        .RST           (rst),
        .PWRSTAT       (pwr),
        .MRST          (mrst),
        .PWRSTAT_STABLE(pwr_stable),
        .MRST_STABLE   (mrst_stable),
        .MODE          (mode),
        .MODE_VALID    (mode_valid),
        .MODE_CHG      (mode_chg),
        .GLITCH_CNT    (glitch_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_p.delete();
        q_m.delete();
        for (int i = 0; i < SYNC; i++) begin
            q_p.push_back(1'b0);
            q_m.push_back(1'b0);
        end
        m_stab_p = 1'b0; m_stab_m = 1'b0;
        m_run_p  = 0;    m_run_m  = 0;
        m_n = 0; m_last = 0; m_g = 0;
        m_mode = 2'b00; m_valid = 1'b0; m_chgp = 1'b0;
    endtask

    // A level is accepted after DEB consecutive differing samples; a shorter run is a glitch
    task automatic deb_one(input logic syn, inout logic stab, inout int run, inout bit moved);
        if (syn !== stab) begin
            run++;
            if (run == DEB) begin
                stab  = syn;
                run   = 0;
                moved = 1'b1;
            end
        end else begin
            if (run > 0) m_g = (m_g >= 255) ? 255 : m_g + 1;
            run = 0;
        end
    endtask

    task automatic model_edge();
        logic sp, sm;
        bit   moved;
        if (rst) begin
            model_reset();
        end else begin
            m_n++;
            sp = q_p.pop_front(); q_p.push_back(pwr);
            sm = q_m.pop_front(); q_m.push_back(mrst);
            if (m_n == SYNC + 1) begin
                m_stab_p = sp;
                m_stab_m = sm;
                m_last   = m_n;
            end else if (m_n > SYNC + 1) begin
                moved = 1'b0;
                deb_one(sp, m_stab_p, m_run_p, moved);
                deb_one(sm, m_stab_m, m_run_m, moved);
                if (moved) m_last = m_n;
            end
            m_valid = (m_n > SYNC) && ((m_n - m_last) >= SETTLE);
            m_chgp  = (m_n > SYNC) && ((m_n - m_last) == SETTLE);
            if (m_chgp) m_mode = {m_stab_p, m_stab_m};
        end
    endtask

    // One clock: advance model on the edge, compare all outputs 1 ns later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pwr_stable",  8'(pwr_stable),  8'(m_stab_p));
        chk("mrst_stable", 8'(mrst_stable), 8'(m_stab_m));
        chk("mode",        8'(mode),        8'(m_mode));
        chk("mode_valid",  8'(mode_valid),  8'(m_valid));
        chk("mode_chg",    8'(mode_chg),    8'(m_chgp));
        chk("glitch_cnt",  glitch_cnt,      8'(m_g));
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        int w;
        rst = 1'b1; pwr = 1'b0; mrst = 1'b0;
        model_reset();

        // Reset, then INIT + settle with both pins low
        steps(2);
        chk("rst_mode",   8'(mode),       8'h00);
        chk("rst_valid",  8'(mode_valid), 8'h00);
        chk("rst_glitch", glitch_cnt,     8'h00);
        rst = 1'b0;
        steps(12);
        chk("valid_before_13", 8'(mode_valid), 8'h00);
        step();
        chk("valid_at_13", 8'(mode_valid), 8'h01);
        chk("chg_at_13",   8'(mode_chg),   8'h01);
        chk("mode_emul",   8'(mode),       8'h00);
        step();
        chk("chg_one_cycle", 8'(mode_chg), 8'h00);

        // MRST rises: accepted 6 edges later, VALID drops on that edge
        mrst = 1'b1;
        steps(5);
        chk("mrst_not_yet", 8'(mrst_stable), 8'h00);
        step();
        chk("mrst_accept",   8'(mrst_stable), 8'h01);
        chk("valid_dropped", 8'(mode_valid),  8'h00);
        steps(9);
        chk("valid_settling", 8'(mode_valid), 8'h00);
        step();
        chk("mode_badrail", 8'(mode),       8'h01);
        chk("valid_again",  8'(mode_valid), 8'h01);
        chk("chg_again",    8'(mode_chg),   8'h01);

        // Short PWRSTAT pulses are rejected and counted, saturating at 255
        for (int k = 0; k < 300; k++) begin
            w = int'($urandom_range(1, 3));
            pwr = 1'b1;
            steps(w);
            pwr = 1'b0;
            steps(6);
            if (k == 0) chk("glitch_first", glitch_cnt, 8'h01);
        end
        chk("glitch_sat",      glitch_cnt,      8'hFF);
        chk("pwr_unchanged",   8'(pwr_stable),  8'h00);
        chk("valid_thru_glch", 8'(mode_valid),  8'h01);

        // A change landing on the settle-completion edge wins
        mrst = 1'b0;
        steps(6);
        chk("mrst_fall", 8'(mrst_stable), 8'h00);
        steps(4);
        mrst = 1'b1;
        steps(6);
        chk("change_wins_valid", 8'(mode_valid),  8'h00);
        chk("change_wins_chg",   8'(mode_chg),    8'h00);
        chk("change_wins_mrst",  8'(mrst_stable), 8'h01);
        steps(9);
        chk("restart_pending", 8'(mode_valid), 8'h00);
        step();
        chk("restart_done", 8'(mode_valid), 8'h01);

        // Both pins rise together: one restart, then STANDBY
        mrst = 1'b0;
        steps(16);
        chk("back_to_emul", 8'(mode), 8'h00);
        pwr = 1'b1; mrst = 1'b1;
        steps(6);
        chk("both_pwr",   8'(pwr_stable),  8'h01);
        chk("both_mrst",  8'(mrst_stable), 8'h01);
        steps(10);
        chk("mode_standby", 8'(mode),     8'h03);
        chk("standby_chg",  8'(mode_chg), 8'h01);
        step();
        chk("standby_chg_end", 8'(mode_chg), 8'h00);

        // One-cycle reset while VALID, INIT re-runs with pins still high
        rst = 1'b1;
        step();
        chk("midrst_mode",   8'(mode),       8'h00);
        chk("midrst_valid",  8'(mode_valid), 8'h00);
        chk("midrst_glitch", glitch_cnt,     8'h00);
        rst = 1'b0;
        steps(13);
        chk("reinit_mode",  8'(mode),       8'h03);
        chk("reinit_valid", 8'(mode_valid), 8'h01);

        // Random pin activity with occasional resets
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            pwr  = 1'($urandom_range(0, 1));
            mrst = 1'($urandom_range(0, 1));
            steps(int'($urandom_range(1, 14)));
        end
        steps(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
